// File: rtl/mem_uart_master.sv
// mem_uart_master: serialises one load/store into command bytes for the UART RAM link.
// Optional read-response timeout enabled by defining MEM_UART_TIMEOUT_EN.
module mem_uart_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_len,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready
);

  typedef enum logic [1:0] {
    IDLE,
    TX,
    RX,
    DONE
  } state_t;

  state_t      state;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  len;
  logic        we;
  logic [3:0]  idx;
  logic [1:0]  rcnt;
  logic [3:0]  last_idx;
  logic        timeout;

  // Reads end after the len byte; writes add len+1 data bytes plus the bit7 mask byte.
  assign last_idx = we ? (4'd8 + {2'b00, len}) : 4'd6;
  assign rx_ready = 1'b1;

  // Command byte k of the current request; only byte 0 carries bit7.
  function automatic logic [7:0] tx_byte(
    input logic [31:0] a,
    input logic [31:0] d,
    input logic [1:0]  n,
    input logic [3:0]  k
  );
    logic [7:0] b;
    logic [3:0] m;
    m = {d[31] & (n == 2'd3),
         d[23] & (n >= 2'd2),
         d[15] & (n >= 2'd1),
         d[7]};
    b = 8'h00;
    case (k)
      4'd1:    b = {1'b0, a[6:0]};
      4'd2:    b = {1'b0, a[14:8]};
      4'd3:    b = {1'b0, a[22:16]};
      4'd4:    b = {1'b0, a[30:24]};
      4'd5:    b = {4'b0, a[31], a[23], a[15], a[7]};
      4'd6:    b = {6'b0, n};
      4'd7:    b = {1'b0, d[6:0]};
      4'd8:    b = (n >= 2'd1) ? {1'b0, d[14:8]} : {4'b0, m};
      4'd9:    b = (n >= 2'd2) ? {1'b0, d[22:16]} : {4'b0, m};
      4'd10:   b = (n == 2'd3) ? {1'b0, d[30:24]} : {4'b0, m};
      4'd11:   b = {4'b0, m};
      default: b = 8'h00;
    endcase
    return b;
  endfunction

`ifdef MEM_UART_TIMEOUT_EN
  logic [31:0] tcnt;

  assign timeout = (state == RX) && !rx_valid &&
                   (tcnt == TIMEOUT_CYCLES - 1);

  // Idle-cycle counter for RX, restarted by every received byte.
  always_ff @(posedge clk) begin
    if (rst || state != RX || rx_valid || timeout) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + 32'd1;
    end
  end

  // One-cycle error pulse when a response byte never arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else begin
      err <= timeout;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  // Request FSM: accept, stream command bytes, gather read data, pulse done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      tx_valid  <= 1'b0;
      tx_data   <= 8'h00;
      done      <= 1'b0;
      rdata     <= '0;
      addr      <= '0;
      wdata     <= '0;
      len       <= '0;
      we        <= 1'b0;
      idx       <= '0;
      rcnt      <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            addr      <= req_addr;
            wdata     <= req_wdata;
            len       <= req_len;
            we        <= req_we;
            idx       <= '0;
            rcnt      <= '0;
            rdata     <= '0;
            tx_valid  <= 1'b1;
            tx_data   <= req_we ? 8'h80 : 8'hC0;
            req_ready <= 1'b0;
            state     <= TX;
          end
        end
        TX: begin
          if (tx_ready) begin
            if (idx == last_idx) begin
              tx_valid <= 1'b0;
              tx_data  <= 8'h00;
              if (we) begin
                done  <= 1'b1;
                state <= DONE;
              end else begin
                state <= RX;
              end
            end else begin
              idx     <= idx + 4'd1;
              tx_data <= tx_byte(addr, wdata, len, idx + 4'd1);
            end
          end
        end
        RX: begin
          if (rx_valid) begin
            rdata[{rcnt, 3'b000} +: 8] <= rx_data;
            rcnt <= rcnt + 2'd1;
            if (rcnt == len) begin
              done  <= 1'b1;
              state <= DONE;
            end
          end else if (timeout) begin
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        DONE: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_uart_master.sv
// tb_mem_uart_master: directed plus randomized transactions against a byte-level model.
// Timeout scenario compiled only with MEM_UART_TIMEOUT_EN.
module tb_mem_uart_master;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_len;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;

  int checks   = 0;
  int failures = 0;
  int err_seen = 0;

  always #5 clk = ~clk;

  mem_uart_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_len   (req_len),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (err === 1'b1) err_seen++;
  endtask

  // Expected command bytes, derived arithmetically from the protocol rules.
  function automatic bq_t model(input bit w, input logic [31:0] a,
                                input logic [31:0] d, input int n);
    bq_t q;
    int  hi;
    int  m;
    q.push_back(w ? 8'h80 : 8'hC0);
    hi = 0;
    for (int i = 0; i < 4; i++) begin
      q.push_back(8'((a >> (8 * i)) & 32'h7F));
      hi = hi | (int'((a >> (8 * i + 7)) & 32'h1) << i);
    end
    q.push_back(8'(hi));
    q.push_back(8'(n));
    if (w) begin
      m = 0;
      for (int i = 0; i <= n; i++) begin
        q.push_back(8'((d >> (8 * i)) & 32'h7F));
        m = m | (int'((d >> (8 * i + 7)) & 32'h1) << i);
      end
      q.push_back(8'(m));
    end
    return q;
  endfunction

  // rdy_pct < 0: hold tx_ready low for 3 cycles while byte k3 is presented.
  task automatic run(input string nm, input bit w, input logic [31:0] a,
                     input logic [31:0] d, input int n, input int rdy_pct,
                     input bit stray_idle);
    bq_t         exp_q;
    bq_t         got_q;
    logic [7:0]  rxb[4];
    logic [31:0] exp_rd;
    logic [7:0]  held_d;
    bit          held_v;
    bit          seen_done;
    int          cyc;
    int          rxi;
    int          stall;
    int          done_cyc;
    exp_q  = model(w, a, d, n);
    exp_rd = '0;
    for (int i = 0; i < 4; i++) begin
      rxb[i] = 8'($urandom);
      if (i <= n) exp_rd = exp_rd | (32'(rxb[i]) << (8 * i));
    end
    if (stray_idle) begin
      rx_valid = 1'b1;
      rx_data  = 8'($urandom);
      step();
      rx_valid = 1'b0;
    end
    chk({nm, " req_ready idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = w;
    req_addr  = a;
    req_wdata = d;
    req_len   = 2'(n);
    step();
    req_valid = 1'b0;
    req_we    = ~w;
    req_addr  = $urandom;
    req_wdata = $urandom;
    req_len   = 2'($urandom);
    chk({nm, " req_ready busy"}, 32'(req_ready), 32'd0);
    cyc       = 0;
    rxi       = 0;
    stall     = 0;
    done_cyc  = 0;
    held_v    = 1'b0;
    held_d    = '0;
    seen_done = 1'b0;
    while (!seen_done && cyc < 3000) begin
      if (held_v) begin
        chk({nm, " held tx_valid"}, 32'(tx_valid), 32'd1);
        chk({nm, " held tx_data"}, 32'(tx_data), 32'(held_d));
      end
      if (rdy_pct < 0) begin
        tx_ready = !(got_q.size() == 3 && stall < 3);
        if (!tx_ready) stall++;
      end else begin
        tx_ready = ($urandom_range(99) < rdy_pct);
      end
      rx_valid = 1'b0;
      if (!w && got_q.size() == exp_q.size() && rxi <= n) begin
        if ($urandom_range(1) == 1) begin
          rx_valid = 1'b1;
          rx_data  = rxb[rxi];
          rxi++;
        end
      end else if (got_q.size() < exp_q.size() && $urandom_range(3) == 0) begin
        rx_valid = 1'b1;
        rx_data  = 8'($urandom);
      end
      if (tx_valid && tx_ready) got_q.push_back(tx_data);
      held_v = tx_valid && !tx_ready;
      held_d = tx_data;
      step();
      cyc++;
      if (done) begin
        seen_done = 1'b1;
        done_cyc  = cyc;
      end
    end
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    chk({nm, " done seen"}, 32'(seen_done), 32'd1);
    chk({nm, " tx count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("%s tx byte %0d", nm, i),
          (i < got_q.size()) ? 32'(got_q[i]) : 32'hxxxxxxxx,
          32'(exp_q[i]));
    end
    if (!w) chk({nm, " rdata"}, rdata, exp_rd);
    if (w && rdy_pct == 100) chk({nm, " done latency"}, done_cyc, exp_q.size());
    chk({nm, " tx idle at done"}, 32'(tx_valid), 32'd0);
    step();
    chk({nm, " done one cycle"}, 32'(done), 32'd0);
    chk({nm, " req_ready after"}, 32'(req_ready), 32'd1);
    if (!w) chk({nm, " rdata held"}, rdata, exp_rd);
  endtask

  initial begin
    bit          rw;
    logic [31:0] ra;
    int          rl;
    int          rdy;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_len   = '0;
    tx_ready  = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = '0;
    step();
    step();
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset tx_valid", 32'(tx_valid), 32'd0);
    chk("reset tx_data", 32'(tx_data), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    chk("reset rdata", rdata, 32'd0);
    chk("rx_ready", 32'(rx_ready), 32'd1);
    rst = 1'b0;
    step();

    run("wr104", 1'b1, 32'h0000_0104, 32'h0000_0041, 0, 100, 1'b0);
    run("rd80000080", 1'b0, 32'h8000_0080, 32'h0, 3, 100, 1'b0);
    run("wr208", 1'b1, 32'h0000_0208, 32'hDEAD_BEEF, 3, 100, 1'b0);
    run("stall_k3", 1'b1, 32'h1234_5678, 32'h8081_8283, 1, -1, 1'b1);

    // Reset in the middle of a read, right after byte k4 is taken.
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h0000_0100;
    req_len   = 2'd0;
    step();
    req_valid = 1'b0;
    tx_ready  = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("abort pre tx_data k5", 32'(tx_data), 32'h00);
    rst = 1'b1;
    step();
    rst      = 1'b0;
    tx_ready = 1'b0;
    chk("abort tx_valid", 32'(tx_valid), 32'd0);
    chk("abort req_ready", 32'(req_ready), 32'd1);
    chk("abort done", 32'(done), 32'd0);
    begin
      int late;
      late = 0;
      for (int i = 0; i < 6; i++) begin
        step();
        if (done || tx_valid) late++;
      end
      chk("abort quiet", late, 0);
    end
    run("after_abort", 1'b0, 32'h0000_0100, 32'h0, 0, 100, 1'b0);

    for (int t = 0; t < 14; t++) begin
      rw  = 1'($urandom);
      ra  = $urandom;
      rl  = $urandom_range(3);
      rdy = $urandom_range(100, 30);
      run($sformatf("rand%0d", t), rw, ra, $urandom, rl, rdy, 1'($urandom));
    end

`ifdef MEM_UART_TIMEOUT_EN
    begin
      int  wait_c;
      int  dn;
      bit  got_err;
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 32'h0000_0040;
      req_len   = 2'd1;
      step();
      req_valid = 1'b0;
      tx_ready  = 1'b1;
      for (int i = 0; i < 7; i++) step();
      tx_ready = 1'b0;
      err_seen = 0;
      wait_c   = 0;
      dn       = 0;
      got_err  = 1'b0;
      while (!got_err && wait_c < 100) begin
        step();
        wait_c++;
        if (done) dn++;
        if (err) got_err = 1'b1;
      end
      chk("timeout err seen", 32'(got_err), 32'd1);
      chk("timeout latency", wait_c, 16);
      chk("timeout no done", dn, 0);
      chk("timeout req_ready", 32'(req_ready), 32'd1);
      step();
      chk("timeout err pulse", 32'(err), 32'd0);
      err_seen = 0;
    end
`endif

    chk("err never pulsed", err_seen, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
